// File: rtl/rdy_vld_merge_fifo_pkg.sv
// rtl/rdy_vld_merge_fifo_pkg.sv - shared constants, tag type and width helper for the merge FIFO
package rdy_vld_merge_fifo_pkg;

    localparam int MERGE_NUM_CH = 3;
    localparam int MERGE_DEPTH  = 8;

    typedef logic [31:0] data_t;

    // Channel index width; a single-channel build still carries one tag bit
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int MERGE_CH_W = ch_width(MERGE_NUM_CH);

    // Tagged beat as seen by downstream consumers of the merged stream
    typedef struct packed {
        logic [MERGE_CH_W-1:0] chan;
        data_t                 payload;
    } merge_tag_st;

endpackage

// File: rtl/rdy_vld_merge_fifo_if.sv
// rtl/rdy_vld_merge_fifo_if.sv - producer/consumer/readback bundle for the merge FIFO
interface rdy_vld_merge_fifo_if
    import rdy_vld_merge_fifo_pkg::*;
#(
    parameter int NUM_CH = MERGE_NUM_CH,
    parameter int DATA_W = $bits(data_t),
    parameter int DEPTH  = MERGE_DEPTH,
    parameter int CNT_W  = 16
);
    localparam int CH_W  = ch_width(NUM_CH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [NUM_CH-1:0]        in_vld;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_rdy;
    logic                     out_vld;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_rdy;
    logic                     flush;
    logic [LVL_W-1:0]         fill_level;
    logic [NUM_CH*CNT_W-1:0]  ch_count;

    // Environment side: producers, consumer and register reader
    modport master (
        output in_vld, in_data, out_rdy, flush,
        input  in_rdy, out_vld, out_data, out_ch, fill_level, ch_count
    );

    // Merge block side
    modport slave (
        input  in_vld, in_data, out_rdy, flush,
        output in_rdy, out_vld, out_data, out_ch, fill_level, ch_count
    );

endinterface

// File: rtl/rdy_vld_merge_fifo_fifo_sync.sv
// rtl/rdy_vld_merge_fifo_fifo_sync.sv - registered DEPTH x WIDTH synchronous FIFO with flush
module rdy_vld_merge_fifo_fifo_sync #(
    parameter int   DEPTH = 8,
    parameter int   WIDTH = 34,
    localparam int  LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    // The extra MSB on each pointer separates a full ring from an empty one
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = i_push && !w_full && !i_flush;
    assign w_do_pop  = i_pop && !w_empty;

    // Pointer update; flush drops everything buffered, including a same-cycle pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (i_flush) begin
                r_rptr <= r_wptr;
            end else if (w_do_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

    // Storage array; cleared on reset so the head reads zero until first write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = LVL_W'(r_wptr - r_rptr);

endmodule

// File: rtl/rdy_vld_merge_fifo.sv
// rtl/rdy_vld_merge_fifo.sv - N-to-1 rdy_vld merge with arbitration, tagged FIFO and beat counters
module rdy_vld_merge_fifo
    import rdy_vld_merge_fifo_pkg::*;
#(
    parameter int NUM_CH   = MERGE_NUM_CH,
    parameter int DATA_W   = $bits(data_t),
    parameter int DEPTH    = MERGE_DEPTH,
    parameter int ARB_MODE = 0,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    rdy_vld_merge_fifo_if.slave bus
);
    localparam int CH_W  = ch_width(NUM_CH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int FW    = CH_W + DATA_W;

    logic [CH_W-1:0]         r_ptr;
    logic [CNT_W-1:0]        r_cnt [NUM_CH];
    logic [CH_W-1:0]         w_winner;
    logic                    w_any;
    logic                    w_accept;
    logic [DATA_W-1:0]       w_sel_data;
    logic [NUM_CH-1:0]       w_in_rdy;
    logic [NUM_CH*CNT_W-1:0] w_ch_count;
    logic [FW-1:0]           w_rdata;
    logic                    w_full;
    logic                    w_empty;
    logic [LVL_W-1:0]        w_level;

    // k-th candidate in search order: from ptr+1 upward (round-robin) or index k-1 (fixed)
    function automatic logic [CH_W-1:0] cand_index(input logic [CH_W-1:0] ptr, input int k);
        int c;
        if (ARB_MODE == 1) begin
            c = k - 1;
        end else begin
            c = (int'(ptr) + k) % NUM_CH;
        end
        return CH_W'(c);
    endfunction

    // Arbiter: scan candidates last-to-first so the earliest candidate in order wins
    always_comb begin
        w_winner = '0;
        w_any    = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (bus.in_vld[cand_index(r_ptr, k)]) begin
                w_winner = cand_index(r_ptr, k);
                w_any    = 1'b1;
            end
        end
    end

    // A full FIFO blocks pushes regardless of a same-cycle pop; flush blocks them too
    assign w_accept = w_any && !w_full && !bus.flush;

    // One-hot ready toward the winning producer only
    always_comb begin
        w_in_rdy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_in_rdy[i] = w_accept && (w_winner == CH_W'(i));
        end
    end

    // Payload mux for the winning channel
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_winner == CH_W'(i)) begin
                w_sel_data = bus.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Round-robin pointer moves to the last accepted channel; starts so ch0 goes first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= CH_W'(NUM_CH - 1);
        end else if (w_accept && (ARB_MODE == 0)) begin
            r_ptr <= w_winner;
        end
    end

    // Per-channel accepted-beat counters, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_accept && (r_cnt[w_winner] != {CNT_W{1'b1}})) begin
            r_cnt[w_winner] <= r_cnt[w_winner] + CNT_W'(1);
        end
    end

    // Flatten counters for readback
    always_comb begin
        w_ch_count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ch_count[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end

    rdy_vld_merge_fifo_fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_wdata ({w_winner, w_sel_data}),
        .i_pop   (bus.out_rdy),
        .i_flush (bus.flush),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign bus.in_rdy     = w_in_rdy;
    assign bus.out_vld    = !w_empty;
    assign bus.out_data   = w_rdata[DATA_W-1:0];
    assign bus.out_ch     = w_rdata[FW-1 -: CH_W];
    assign bus.fill_level = w_level;
    assign bus.ch_count   = w_ch_count;

endmodule

// File: tb/tb_rdy_vld_merge_fifo.sv
// tb/tb_rdy_vld_merge_fifo.sv - directed self-checking bench for rdy_vld_merge_fifo
module tb_rdy_vld_merge_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // Instance A: round-robin, narrow counters for saturation; instance B: fixed priority
    rdy_vld_merge_fifo_if #(.NUM_CH(3), .DATA_W(32), .DEPTH(8), .CNT_W(4))  bus_a ();
    rdy_vld_merge_fifo_if #(.NUM_CH(3), .DATA_W(32), .DEPTH(8), .CNT_W(16)) bus_b ();

    rdy_vld_merge_fifo #(.NUM_CH(3), .DATA_W(32), .DEPTH(8), .ARB_MODE(0), .CNT_W(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    rdy_vld_merge_fifo #(.NUM_CH(3), .DATA_W(32), .DEPTH(8), .ARB_MODE(1), .CNT_W(16)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    typedef struct {
        logic [2:0] vld;
        logic [2:0] exp_rdy;
        logic       exp_ovld;
        logic [1:0] exp_ch;
        logic [3:0] exp_fill;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus_a.in_vld = '0; bus_a.out_rdy = 1'b0; bus_a.flush = 1'b0;
        bus_b.in_vld = '0; bus_b.out_rdy = 1'b0; bus_b.flush = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] cnt_a(input int i);
        return bus_a.ch_count[i*4 +: 4];
    endfunction

    function automatic logic [15:0] cnt_b(input int i);
        return bus_b.ch_count[i*16 +: 16];
    endfunction

    initial begin
        logic [31:0] n;

        bus_a.in_data = '0;
        bus_b.in_data = '0;

        // Round-robin vectors: row expectations are the state seen before that row's edge
        tbl[0]  = '{3'b111, 3'b001, 1'b0, 2'd0, 4'd0};
        tbl[1]  = '{3'b111, 3'b010, 1'b1, 2'd0, 4'd1};
        tbl[2]  = '{3'b111, 3'b100, 1'b1, 2'd1, 4'd1};
        tbl[3]  = '{3'b111, 3'b001, 1'b1, 2'd2, 4'd1};
        tbl[4]  = '{3'b111, 3'b010, 1'b1, 2'd0, 4'd1};
        tbl[5]  = '{3'b111, 3'b100, 1'b1, 2'd1, 4'd1};
        tbl[6]  = '{3'b111, 3'b001, 1'b1, 2'd2, 4'd1};
        tbl[7]  = '{3'b111, 3'b010, 1'b1, 2'd0, 4'd1};
        tbl[8]  = '{3'b111, 3'b100, 1'b1, 2'd1, 4'd1};
        tbl[9]  = '{3'b111, 3'b001, 1'b1, 2'd2, 4'd1};
        tbl[10] = '{3'b111, 3'b010, 1'b1, 2'd0, 4'd1};
        tbl[11] = '{3'b111, 3'b100, 1'b1, 2'd1, 4'd1};
        tbl[12] = '{3'b101, 3'b001, 1'b1, 2'd2, 4'd1};
        tbl[13] = '{3'b101, 3'b100, 1'b1, 2'd0, 4'd1};
        tbl[14] = '{3'b101, 3'b001, 1'b1, 2'd2, 4'd1};
        tbl[15] = '{3'b000, 3'b000, 1'b1, 2'd0, 4'd1};
        tbl[16] = '{3'b000, 3'b000, 1'b0, 2'd0, 4'd0};

        // Reset state
        do_reset();
        #1;
        chk("rst_out_vld",  64'(bus_a.out_vld), 64'd0);
        chk("rst_fill",     64'(bus_a.fill_level), 64'd0);
        chk("rst_out_data", 64'(bus_a.out_data), 64'd0);
        chk("rst_out_ch",   64'(bus_a.out_ch), 64'd0);
        chk("rst_counts",   64'(bus_a.ch_count), 64'd0);
        chk("rst_in_rdy",   64'(bus_a.in_rdy), 64'd0);
        tick();

        // Round-robin table
        bus_a.in_data = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        for (int r = 0; r < 17; r++) begin
            bus_a.in_vld  = tbl[r].vld;
            bus_a.out_rdy = 1'b1;
            #1;
            chk($sformatf("rr_in_rdy[%0d]", r),  64'(bus_a.in_rdy), 64'(tbl[r].exp_rdy));
            chk($sformatf("rr_out_vld[%0d]", r), 64'(bus_a.out_vld), 64'(tbl[r].exp_ovld));
            chk($sformatf("rr_fill[%0d]", r),    64'(bus_a.fill_level), 64'(tbl[r].exp_fill));
            if (tbl[r].exp_ovld) begin
                chk($sformatf("rr_out_ch[%0d]", r),   64'(bus_a.out_ch), 64'(tbl[r].exp_ch));
                chk($sformatf("rr_out_data[%0d]", r), 64'(bus_a.out_data),
                    64'(32'hD000_0000 + 32'(tbl[r].exp_ch)));
            end
            tick();
        end
        chk("rr_cnt0", 64'(cnt_a(0)), 64'd6);
        chk("rr_cnt1", 64'(cnt_a(1)), 64'd4);
        chk("rr_cnt2", 64'(cnt_a(2)), 64'd5);

        // Single channel: ch1 sends A1,A2,A3
        do_reset();
        bus_a.in_data = '0;
        bus_a.in_data[32 +: 32] = 32'hA1A1_0001;
        bus_a.in_vld = 3'b010;
        bus_a.out_rdy = 1'b1;
        #1;
        chk("sc_in_rdy", 64'(bus_a.in_rdy), 64'b010);
        chk("sc_no_bypass", 64'(bus_a.out_vld), 64'd0);
        tick();
        chk("sc_vld1", 64'(bus_a.out_vld), 64'd1);
        chk("sc_ch1",  64'(bus_a.out_ch), 64'd1);
        chk("sc_d1",   64'(bus_a.out_data), 64'hA1A1_0001);
        bus_a.in_data[32 +: 32] = 32'hA2A2_0002;
        tick();
        chk("sc_d2",   64'(bus_a.out_data), 64'hA2A2_0002);
        chk("sc_ch2",  64'(bus_a.out_ch), 64'd1);
        bus_a.in_data[32 +: 32] = 32'hA3A3_0003;
        tick();
        chk("sc_d3",   64'(bus_a.out_data), 64'hA3A3_0003);
        bus_a.in_vld = 3'b000;
        tick();
        chk("sc_drained", 64'(bus_a.out_vld), 64'd0);
        chk("sc_cnt0", 64'(cnt_a(0)), 64'd0);
        chk("sc_cnt1", 64'(cnt_a(1)), 64'd3);
        chk("sc_cnt2", 64'(cnt_a(2)), 64'd0);

        // Full backpressure: 10 beats offered into 8 entries
        do_reset();
        n = 0;
        bus_a.in_vld = 3'b001;
        bus_a.out_rdy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus_a.in_data[0 +: 32] = 32'hB000_0000 + n;
            #1;
            chk($sformatf("bp_in_rdy[%0d]", c), 64'(bus_a.in_rdy), (c < 8) ? 64'b001 : 64'b000);
            chk($sformatf("bp_fill[%0d]", c), 64'(bus_a.fill_level), (c < 8) ? 64'(c) : 64'd8);
            tick();
            if (c < 8) n++;
        end
        bus_a.in_data[0 +: 32] = 32'hB000_0000 + n;
        chk("bp_full_fill", 64'(bus_a.fill_level), 64'd8);
        chk("bp_full_head", 64'(bus_a.out_data), 64'hB000_0000);
        bus_a.out_rdy = 1'b1;
        #1;
        chk("bp_pop_no_push", 64'(bus_a.in_rdy), 64'b000);
        tick();
        bus_a.out_rdy = 1'b0;
        #1;
        chk("bp_after_pop_fill", 64'(bus_a.fill_level), 64'd7);
        chk("bp_after_pop_rdy",  64'(bus_a.in_rdy), 64'b001);
        chk("bp_after_pop_head", 64'(bus_a.out_data), 64'hB000_0001);
        tick();
        chk("bp_refill", 64'(bus_a.fill_level), 64'd8);
        chk("bp_cnt0",   64'(cnt_a(0)), 64'd9);

        // Flush with 5 entries buffered and a simultaneous pop
        do_reset();
        bus_a.in_vld = 3'b001;
        for (int c = 0; c < 5; c++) begin
            bus_a.in_data[0 +: 32] = 32'hF000_0000 + 32'(c);
            tick();
        end
        bus_a.in_data[0 +: 32] = 32'hF000_0005;
        chk("fl_fill5", 64'(bus_a.fill_level), 64'd5);
        bus_a.flush = 1'b1;
        bus_a.out_rdy = 1'b1;
        #1;
        chk("fl_in_rdy", 64'(bus_a.in_rdy), 64'b000);
        tick();
        bus_a.flush = 1'b0;
        bus_a.in_vld = 3'b000;
        bus_a.out_rdy = 1'b0;
        #1;
        chk("fl_out_vld", 64'(bus_a.out_vld), 64'd0);
        chk("fl_fill",    64'(bus_a.fill_level), 64'd0);
        chk("fl_cnt0",    64'(cnt_a(0)), 64'd5);
        tick();

        // Saturation with CNT_W=4, then asynchronous reset mid-stream
        do_reset();
        bus_a.in_vld = 3'b001;
        bus_a.out_rdy = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        chk("sat_cnt0", 64'(cnt_a(0)), 64'd15);
        chk("sat_busy", 64'(bus_a.out_vld), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_vld", 64'(bus_a.out_vld), 64'd0);
        chk("async_fill",    64'(bus_a.fill_level), 64'd0);
        chk("async_counts",  64'(bus_a.ch_count), 64'd0);
        bus_a.in_vld = 3'b000;
        bus_a.out_rdy = 1'b0;
        tick();
        rst_n = 1'b1;

        // Fixed priority on instance B: ch0 starves ch2 until it drops valid
        bus_b.in_data = {32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
        bus_b.in_vld = 3'b101;
        bus_b.out_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("fp_in_rdy[%0d]", c), 64'(bus_b.in_rdy), 64'b001);
            if (c > 0) chk($sformatf("fp_out_ch[%0d]", c), 64'(bus_b.out_ch), 64'd0);
            tick();
        end
        bus_b.in_vld = 3'b100;
        #1;
        chk("fp_ch2_rdy", 64'(bus_b.in_rdy), 64'b100);
        tick();
        bus_b.in_vld = 3'b000;
        chk("fp_ch2_out",  64'(bus_b.out_ch), 64'd2);
        chk("fp_ch2_data", 64'(bus_b.out_data), 64'hC000_0002);
        chk("fp_cnt0", 64'(cnt_b(0)), 64'd4);
        chk("fp_cnt1", 64'(cnt_b(1)), 64'd0);
        chk("fp_cnt2", 64'(cnt_b(2)), 64'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rdy_vld_merge_fifo.md
Name: rdy_vld_merge_fifo

Overview:
- Parametrised successor to the fixed three-way `threeCs` / `blockF` rdy_vld plumbing: merges NUM_CH rdy_vld producer channels into a single buffered rdy_vld consumer stream.
- Arbitration is round-robin or fixed-priority. Each accepted beat is tagged with its source channel and held in a DEPTH-entry FIFO.
- Exposes a fill level and per-channel saturating beat counters for register readback. Sits between stage outputs and a shared downstream consumer inside a container block.

Parameters:
- NUM_CH, 3, number of input channels (2..16).
- DATA_W, 32, payload width; the SV wrapper binds it as $bits(data_t).
- DEPTH, 8, FIFO entries; power of two, >=2.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- CNT_W, 16, width of each per-channel beat counter.
- Derived: CH_W = max(1,$clog2(NUM_CH)); LVL_W = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_vld  in  NUM_CH  per-channel valid.
- in_data  in  NUM_CH*DATA_W  per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W].
- in_rdy  out  NUM_CH  per-channel ready.
- out_vld  out  1  output valid.
- out_data  out  DATA_W  head payload.
- out_ch  out  CH_W  source channel of the head entry.
- out_rdy  in  1  consumer ready.
- flush  in  1  synchronous FIFO clear.
- fill_level  out  LVL_W  current number of occupied entries.
- ch_count  out  NUM_CH*CNT_W  accepted beats per channel, saturating.

Behaviour:
- Reset (rst_n low, async):
  - FIFO read/write pointers = 0; fill_level = 0; out_vld = 0.
  - out_data = 0; out_ch = 0; all ch_count = 0; arbitration pointer = NUM_CH-1, so channel 0 has first priority.
- Arbitration (combinational):
  - Round-robin: winner = first i with in_vld[i], searching from ptr+1 upward modulo NUM_CH.
  - Fixed priority: winner = lowest i with in_vld[i].
- Ready:
  - in_rdy[i] = (i == winner) && in_vld[i] && !full && !flush.
  - At most one in_rdy is high per cycle.
  - in_rdy does not depend on out_rdy. A full FIFO blocks pushes even if a pop occurs in the same cycle.
- Push: a beat is accepted when in_vld[i] && in_rdy[i] at the clock edge.
  - {i, in_data[i]} is written at wptr; wptr increments and wraps modulo DEPTH.
  - In round-robin mode, ptr <= winner on accept only. ptr is unchanged when nothing is accepted.
- Pop:
  - out_vld = !empty; out_data/out_ch come from a registered array indexed by rptr.
  - A pop occurs when out_vld && out_rdy; rptr increments and wraps.
- Latency: a beat accepted at edge N is presented on out_vld after edge N (visible in cycle N+1). No bypass path.
- Push and pop in the same cycle when neither full nor empty: both occur and fill_level is unchanged.
- Push and pop in the same cycle when empty: push only, because out_vld was 0.
- Occupancy tracking: an extra pointer bit distinguishes full from empty. fill_level = wptr - rptr over LVL_W bits.
- Producer rule: a producer must hold in_vld and in_data stable until it is accepted. The block does not check this.
- Output stability: out_data and out_ch stay stable while out_vld && !out_rdy.
- Flush (synchronous, one cycle):
  - rptr <= wptr, so the FIFO is empty next cycle; the arbitration pointer is unchanged.
  - in_rdy is forced low, so no push occurs that cycle. A pop occurring in the same cycle is discarded.
  - ch_count is not cleared.
- Counters:
  - ch_count[i] increments on each accepted beat from channel i and saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by reset.
- Reset mid-transfer: all state is cleared immediately and asynchronously; in-flight entries are lost; out_vld drops in the same cycle.

Decomposition:
- Shared package (mixedInclude_package): constants MERGE_NUM_CH and MERGE_DEPTH, and typedef mergeTagSt {chan, data_t payload} reused by downstream consumers.
- Sub-module fifo_sync: a parametrised DEPTH×width synchronous FIFO with push, pop, flush, full, empty and level outputs.
- The arbiter and counters live in the top module.

Test Plan:
- Single channel: ch1 sends A1,A2,A3 with out_rdy=1 -> out_data A1,A2,A3 each with out_ch=1. First out_vld appears the cycle after accept. ch_count[1]=3, others 0.
- Round-robin: all 3 channels continuously valid, out_rdy=1, ARB_MODE=0 -> accept order 0,1,2,0,1,2; each ch_count=4 after 12 beats.
- Fixed priority: ARB_MODE=1, ch0 and ch2 continuously valid -> only ch0 accepted; in_rdy[2] stays 0 until ch0 drops vld.
- Full backpressure: out_rdy=0, 10 beats offered, DEPTH=8 -> 8 accepted, fill_level=8, all in_rdy=0. Raising out_rdy for 1 cycle pops one entry; the next push occurs only on the following cycle.
- Flush: 5 entries buffered, flush pulsed together with out_rdy=1 -> next cycle out_vld=0 and fill_level=0; no push accepted in the flush cycle; ch_count unchanged.
- Saturation and reset: CNT_W=4, 20 beats on ch0 -> ch_count[0]=15. Asserting rst_n=0 mid-stream -> out_vld, fill_level and ch_count are all 0 immediately, without waiting for a clock edge.
